// File: rtl/mcoi_stepper_bank.sv
// Multi-channel stepper pulse generator: per-channel move FSM, input synchronisers, sticky pfail fault.
// Optional build macro MCOI_STEP_INTERLOCK_EN: end switch in travel direction stops the move safely.
package mcoi_stepper_pkg;
  typedef struct packed {
    logic clk;
    logic reset;
  } ckrs_t;
endpackage

module mcoi_stepper_bank
  import mcoi_stepper_pkg::*;
#(
  parameter int NUM_MOTORS = 16,
  parameter int CNT_W      = 32,
  parameter int DIV_W      = 16,
  parameter int DIR_SETUP  = 4
) (
  input  ckrs_t                                ClkRs_ix,
  input  logic [NUM_MOTORS-1:0]                cmd_valid_i,
  output logic [NUM_MOTORS-1:0]                cmd_ready_o,
  input  logic [NUM_MOTORS-1:0][CNT_W-1:0]     cmd_steps_i,
  input  logic [NUM_MOTORS-1:0]                cmd_dir_i,
  input  logic [NUM_MOTORS-1:0][DIV_W-1:0]     cmd_half_i,
  input  logic [NUM_MOTORS-1:0]                enable_i,
  input  logic [NUM_MOTORS-1:0]                abort_i,
  input  logic [NUM_MOTORS-1:0]                fault_clr_i,
  output logic [NUM_MOTORS-1:0]                busy_o,
  output logic [NUM_MOTORS-1:0]                done_o,
  output logic [NUM_MOTORS-1:0]                fault_o,
  output logic [NUM_MOTORS-1:0][CNT_W-1:0]     steps_left_o,
  output logic [NUM_MOTORS-1:0]                pl_clk,
  output logic [NUM_MOTORS-1:0]                pl_dir,
  output logic [NUM_MOTORS-1:0]                pl_en,
  output logic [NUM_MOTORS-1:0]                pl_boost,
  input  logic [NUM_MOTORS-1:0]                pl_pfail,
  input  logic [NUM_MOTORS-1:0]                pl_sw_outa,
  input  logic [NUM_MOTORS-1:0]                pl_sw_outb,
  output logic [NUM_MOTORS-1:0]                sw_a_o,
  output logic [NUM_MOTORS-1:0]                sw_b_o
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW} state_t;

  logic clk, rst;
  assign clk = ClkRs_ix.clk;
  assign rst = ClkRs_ix.reset;

  logic [NUM_MOTORS-1:0] pf_s1_q, pf_s2_q, pf_prev_q;
  logic [NUM_MOTORS-1:0] swa_s1_q, swa_s2_q, swb_s1_q, swb_s2_q;
  logic [NUM_MOTORS-1:0] en_q, pf_rise;
  logic                  alive_q;

  // alive_q keeps cmd_ready_o low while reset is asserted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pf_s1_q   <= '0;
      pf_s2_q   <= '0;
      pf_prev_q <= '0;
      swa_s1_q  <= '0;
      swa_s2_q  <= '0;
      swb_s1_q  <= '0;
      swb_s2_q  <= '0;
      en_q      <= '0;
      alive_q   <= 1'b0;
    end else begin
      pf_s1_q   <= pl_pfail;
      pf_s2_q   <= pf_s1_q;
      pf_prev_q <= pf_s2_q;
      swa_s1_q  <= pl_sw_outa;
      swa_s2_q  <= swa_s1_q;
      swb_s1_q  <= pl_sw_outb;
      swb_s2_q  <= swb_s1_q;
      en_q      <= enable_i;
      alive_q   <= 1'b1;
    end
  end

  assign pf_rise = pf_s2_q & ~pf_prev_q;
  assign pl_en   = en_q;
  assign sw_a_o  = swa_s2_q;
  assign sw_b_o  = swb_s2_q;

  for (genvar m = 0; m < NUM_MOTORS; m++) begin : g_ch
    state_t             state_q;
    logic [DIV_W-1:0]   cnt_q, half_q;
    logic [CNT_W-1:0]   steps_q;
    logic               dir_q, clk_q, boost_q, busy_q, done_q, fault_q, pend_q;
    logic               stop, sw_hit, accept;

    always_comb begin
      sw_hit = 1'b0;
`ifdef MCOI_STEP_INTERLOCK_EN
      sw_hit = dir_q ? swa_s2_q[m] : swb_s2_q[m];
`endif
      stop   = abort_i[m] | pf_rise[m];
      accept = cmd_valid_i[m] & cmd_ready_o[m];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
        half_q  <= '0;
        steps_q <= '0;
        dir_q   <= 1'b0;
        clk_q   <= 1'b0;
        boost_q <= 1'b0;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
        fault_q <= 1'b0;
        pend_q  <= 1'b0;
      end else begin
        done_q <= 1'b0;
        if (pf_s2_q[m])          fault_q <= 1'b1;
        else if (fault_clr_i[m]) fault_q <= 1'b0;
        case (state_q)
          S_IDLE: begin
            pend_q <= 1'b0;
            if (accept) begin
              dir_q   <= cmd_dir_i[m];
              steps_q <= cmd_steps_i[m];
              half_q  <= (cmd_half_i[m] == '0) ? DIV_W'(1) : cmd_half_i[m];
              cnt_q   <= DIV_W'(1);
              if (cmd_steps_i[m] == '0) begin
                done_q <= 1'b1;
              end else begin
                state_q <= S_SETUP;
                busy_q  <= 1'b1;
                boost_q <= 1'b1;
              end
            end
          end
          S_SETUP: begin
            // The interlock switch is only evaluated once the direction setup time has elapsed
            if (stop || (cnt_q == DIV_W'(DIR_SETUP) && sw_hit)) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              boost_q <= 1'b0;
              done_q  <= 1'b1;
            end else if (cnt_q == DIV_W'(DIR_SETUP)) begin
              state_q <= S_HIGH;
              clk_q   <= 1'b1;
              cnt_q   <= DIV_W'(1);
            end else begin
              cnt_q <= cnt_q + DIV_W'(1);
            end
          end
          S_HIGH: begin
            if (cnt_q == half_q) begin
              clk_q <= 1'b0;
              cnt_q <= DIV_W'(1);
              if (steps_q != '0) steps_q <= steps_q - CNT_W'(1);
              if (pend_q || stop || sw_hit) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                boost_q <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q <= S_LOW;
              end
            end else begin
              cnt_q <= cnt_q + DIV_W'(1);
              if (stop || sw_hit) pend_q <= 1'b1;
            end
          end
          S_LOW: begin
            if (stop || sw_hit || (cnt_q == half_q && steps_q == '0)) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              boost_q <= 1'b0;
              done_q  <= 1'b1;
            end else if (cnt_q == half_q) begin
              state_q <= S_HIGH;
              clk_q   <= 1'b1;
              cnt_q   <= DIV_W'(1);
            end else begin
              cnt_q <= cnt_q + DIV_W'(1);
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end

    assign cmd_ready_o[m]  = alive_q & (state_q == S_IDLE) & ~fault_q;
    assign busy_o[m]       = busy_q;
    assign done_o[m]       = done_q;
    assign fault_o[m]      = fault_q;
    assign steps_left_o[m] = steps_q;
    assign pl_clk[m]       = clk_q;
    assign pl_dir[m]       = dir_q;
    assign pl_boost[m]     = boost_q;
  end

endmodule
